// File: rtl/reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_release_sequencer
// Description : Staged reset generator. The async_i input forces every reset
//               output high at once. Release is synchronized to clk_i,
//               qualified by a synchronized lock, stretched by a hold counter
//               and then applied one output at a time, GAP_CYCLES apart.
// Ports       : clk_i      - single clock, rising edge
//               async_i    - asynchronous active-high reset, clears all state
//               lock_i     - asynchronous qualifier (e.g. PLL locked)
//               soft_req_i - synchronous one-cycle request to re-run sequence
//               rst_out_o  - NUM_OUTS active-high resets, bit 0 released first
//               ready_o    - high once every rst_out_o bit is released
// Revision    : 1.0 - initial release
// ============================================================================
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,   // synchronizer depth, >= 2
  parameter int HOLD_CYCLES = 16,  // qualified cycles before first release, >= 1
  parameter int NUM_OUTS    = 3,   // number of staged outputs, >= 1
  parameter int GAP_CYCLES  = 4    // cycles between releases, >= 1
) (
  input  logic                clk_i,
  input  logic                async_i,
  input  logic                lock_i,
  input  logic                soft_req_i,
  output logic [NUM_OUTS-1:0] rst_out_o,
  output logic                ready_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam int IDX_W  = $clog2(NUM_OUTS + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_DONE  = IDX_W'(NUM_OUTS);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Synchronizer chains. Only stage 0 may see a recovery violation when
  // async_i falls close to a clock edge; the remaining stages resolve it.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   sync_ok;
  logic                   lock_s;

  logic [1:0]          state_q,   state_d;
  logic [HOLD_W-1:0]   hold_q,    hold_d;
  logic [GAP_W-1:0]    gap_q,     gap_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                ready_q,   ready_d;

  assign sync_ok = rst_sync_q[SYNC_STAGES-1];
  assign lock_s  = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge async_i) begin
    if (async_i) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    if (soft_req_i || !lock_s) begin
      // Abort from any state: back to the reset values on this edge.
      state_d   = ST_HOLD;
      hold_d    = '0;
      gap_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // sync_ok low with lock_s high only occurs while the reset chain
          // is still filling; the count simply waits.
          if (sync_ok) begin
            if (hold_q == HOLD_LAST) begin
              state_d      = ST_RELEASE;
              hold_d       = '0;
              gap_d        = '0;
              idx_d        = IDX_W'(1);
              rst_out_d[0] = 1'b0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end

        ST_RELEASE: begin
          // ready follows one edge after the final bit clears, so with a
          // single output this state is left on the very next edge.
          if (idx_q == IDX_DONE) begin
            state_d   = ST_RUN;
            gap_d     = '0;
            idx_d     = '0;
            rst_out_d = '0;
            ready_d   = 1'b1;
          end else if (gap_q == GAP_LAST) begin
            gap_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int i = 0; i < NUM_OUTS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rst_out_d[i] = 1'b0;
              end
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end

        ST_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end

        default: begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          gap_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from flops so they cannot glitch.
  always_ff @(posedge clk_i or posedge async_i) begin
    if (async_i) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_out_o = rst_out_q;
  assign ready_o   = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_release_sequencer
// Description : Self-checking bench for reset_release_sequencer. A reference
//               model counts qualified edges and release time and pushes the
//               expected outputs each edge; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_release_sequencer;

  localparam int S = 2;
  localparam int H = 16;
  localparam int N = 3;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         async_r;
  logic         lock_r;
  logic         soft_r;
  logic         soft2_r;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [0:0]   rst_out2;
  logic         ready2;

  int checks = 0;
  int errors = 0;

  reset_release_sequencer #(
    .SYNC_STAGES(S), .HOLD_CYCLES(H), .NUM_OUTS(N), .GAP_CYCLES(G)
  ) dut (
    .clk_i(clk), .async_i(async_r), .lock_i(lock_r), .soft_req_i(soft_r),
    .rst_out_o(rst_out), .ready_o(ready)
  );

  reset_release_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUTS(1), .GAP_CYCLES(1)
  ) dut_min (
    .clk_i(clk), .async_i(async_r), .lock_i(lock_r), .soft_req_i(soft2_r),
    .rst_out_o(rst_out2), .ready_o(ready2)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Higher-level view: count qualified edges since the last (re)start; once
  // H are seen the sequence is "released" and outputs are a function of the
  // number of edges elapsed since release.
  int           m_e, m_c, m_t;
  bit           m_rel;
  bit [S-1:0]   m_lp;
  bit           m_lock_s, m_sync_ok;
  logic [N:0]   exp_q[$];
  logic [N-1:0] m_er;
  logic         m_erdy;

  always @(posedge clk) begin
    if (async_r) begin
      m_e = 0; m_c = 0; m_t = 0; m_rel = 1'b0; m_lp = '0;
    end else begin
      m_lock_s  = m_lp[S-1];
      m_sync_ok = (m_e >= S);
      if (m_e < 1000) m_e++;
      if (soft_r || !m_lock_s) begin
        m_c = 0; m_rel = 1'b0; m_t = 0;
      end else if (!m_rel) begin
        if (m_sync_ok) begin
          m_c++;
          if (m_c == H) begin m_rel = 1'b1; m_t = 0; end
        end
      end else if (m_t < 1000) begin
        m_t++;
      end
      m_lp = {m_lp[S-2:0], lock_r};
    end
    for (int i = 0; i < N; i++) m_er[i] = !(m_rel && (m_t >= i * G));
    m_erdy = m_rel && (m_t >= (N - 1) * G + 1);
    exp_q.push_back({m_er, m_erdy});
  end

  // -------------------------------------------------------------- monitor
  logic [N:0] mon_exp;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if ({rst_out, ready} !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t {rst_out,ready} actual=%b required=%b",
                 $time, {rst_out, ready}, mon_exp);
      end
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Assert async between edges; outputs must reset with no clock edge.
  task automatic async_pulse();
    @(negedge clk);
    #2 async_r = 1'b1;
    #1;
    check("async_immediate_rst", 32'(rst_out), 32'(3'b111));
    check("async_immediate_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    #3 async_r = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    async_r = 1'b1; lock_r = 1'b1; soft_r = 1'b0; soft2_r = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rst_out", 32'(rst_out), 32'(3'b111));
    check("reset_ready", 32'(ready), 32'd0);
    #1 async_r = 1'b0;

    // Nominal sequence with edge-accurate expectations.
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #2;
      case (k)
        2:  check("min_rst_edge2", 32'(rst_out2), 32'd1);
        3:  begin
              check("min_rst_edge3", 32'(rst_out2), 32'd0);
              check("min_ready_edge3", 32'(ready2), 32'd0);
            end
        4:  check("min_ready_edge4", 32'(ready2), 32'd1);
        17: check("nom_rst_edge17", 32'(rst_out), 32'(3'b111));
        18: check("nom_rst_edge18", 32'(rst_out), 32'(3'b110));
        21: check("nom_rst_edge21", 32'(rst_out), 32'(3'b110));
        22: check("nom_rst_edge22", 32'(rst_out), 32'(3'b100));
        26: begin
              check("nom_rst_edge26", 32'(rst_out), 32'd0);
              check("nom_ready_edge26", 32'(ready), 32'd0);
            end
        27: check("nom_ready_edge27", 32'(ready), 32'd1);
        default: ;
      endcase
    end

    // Soft request in RUN.
    @(negedge clk) soft_r = 1'b1;
    @(posedge clk);
    #2;
    check("soft_rst_out", 32'(rst_out), 32'(3'b111));
    check("soft_ready", 32'(ready), 32'd0);
    @(negedge clk) soft_r = 1'b0;
    repeat (30) @(negedge clk);

    // Restart, then a 3-cycle lock glitch while in HOLD.
    @(negedge clk) soft_r = 1'b1;
    @(negedge clk) soft_r = 1'b0;
    repeat (8) @(negedge clk);
    lock_r = 1'b0;
    repeat (3) @(negedge clk);
    lock_r = 1'b1;
    repeat (40) @(negedge clk);

    // Async pulse in the middle of the release phase.
    async_pulse();
    for (int k = 1; k < 23; k++) @(posedge clk);
    @(posedge clk);
    #2 async_r = 1'b1;
    #1;
    check("async_mid_release_rst", 32'(rst_out), 32'(3'b111));
    check("async_mid_release_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    #3 async_r = 1'b0;
    repeat (35) @(negedge clk);

    // Randomized phase.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      soft_r = ($urandom_range(0, 99) < 2);
      if (lock_r) lock_r = ($urandom_range(0, 199) != 0);
      else        lock_r = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        soft_r = 1'b0;
        async_pulse();
      end
    end

    @(negedge clk) soft_r = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
